cache_mem_responder: RTL and testbench

//  Memory-side responder for the cache<->memory block handshake. Accepts one 32-bit

---
 rtl/cache_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_cache_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// ----------------------------------------------------------------------------
// cache_mem_responder
//
// Memory-side responder for the cache <-> memory block handshake. Accepts one
// block load or store at a time, services it after LATENCY cycles and then
// completes a four-phase req/complete handshake with the cache.
//
// Parameters
//   D_WIDTH     block width in bits (one cache block per access)
//   WIDTH_AD    byte-address width from the cache
//   DEPTH_LOG2  log2 of the number of D_WIDTH words in the backing array
//   LATENCY     cycles from request acceptance to completion assert (1..15)
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   address_in       in   byte address; word index = address_in[DEPTH_LOG2+1:2]
//   data_in          in   block to store
//   wren             in   store request (level, held until store_completed)
//   mem_load_req     in   load request (level, held until load_completed)
//   data_out         out  loaded block, valid while load_completed is high
//   load_completed   out  load data valid; held until mem_load_req drops
//   store_completed  out  store written; held until wren drops
//   load_toggle      out  flips once per completed load
//   busy             out  high in every state other than IDLE
// ----------------------------------------------------------------------------
module cache_mem_responder #(
  parameter int D_WIDTH    = 32,
  parameter int WIDTH_AD   = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH_AD-1:0] address_in,
  input  logic [D_WIDTH-1:0]  data_in,
  input  logic                wren,
  input  logic                mem_load_req,
  output logic [D_WIDTH-1:0]  data_out,
  output logic                load_completed,
  output logic                store_completed,
  output logic                load_toggle,
  output logic                busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_DONE,
    STORE_WAIT,
    STORE_DONE,
    RELEASE
  } state_t;

  typedef logic [DEPTH-1:0][D_WIDTH-1:0] mem_t;

  // The counter is four bits wide, so anything outside 1..15 cannot be timed.
  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("cache_mem_responder: LATENCY must be within 1..15");
    end
  endgenerate

  // Simulation contents start as mem[i] = i so loads of untouched words are
  // predictable; reset deliberately leaves the array alone.
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = D_WIDTH'(i);
    end
    return m;
  endfunction

  mem_t                  mem = init_mem();
  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [D_WIDTH-1:0]    data_q;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic                  store_fire;

  assign idx_in = address_in[DEPTH_LOG2+1:2];

  // Byte-offset bits and bits above the word index play no part in addressing.
  generate
    if (WIDTH_AD > DEPTH_LOG2 + 2) begin : g_addr_hi
      logic unused_addr_bits;
      assign unused_addr_bits = ^{address_in[1:0], address_in[WIDTH_AD-1:DEPTH_LOG2+2]};
    end else begin : g_addr_lo
      logic unused_addr_bits;
      assign unused_addr_bits = ^address_in[1:0];
    end
  endgenerate

  // The store lands in the same edge that raises store_completed, so a load
  // accepted after the handshake always sees the new data.
  assign store_fire = (state == STORE_WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (store_fire) begin
      mem[idx_q] <= data_q;
    end
  end

  // Handshake FSM. Stores win over loads in IDLE; a load left pending is
  // picked up after the store's handshake and the RELEASE gap. Requests that
  // drop during *_WAIT still complete the access before releasing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      idx_q           <= '0;
      data_q          <= '0;
      data_out        <= '0;
      load_completed  <= 1'b0;
      store_completed <= 1'b0;
      load_toggle     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wren) begin
            idx_q  <= idx_in;
            data_q <= data_in;
            cnt    <= LAT_M1;
            busy   <= 1'b1;
            state  <= STORE_WAIT;
          end else if (mem_load_req) begin
            idx_q <= idx_in;
            cnt   <= LAT_M1;
            busy  <= 1'b1;
            state <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (cnt == 4'd0) begin
            data_out       <= mem[idx_q];
            load_completed <= 1'b1;
            load_toggle    <= ~load_toggle;
            state          <= LOAD_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        LOAD_DONE: begin
          if (!mem_load_req) begin
            load_completed <= 1'b0;
            state          <= RELEASE;
          end
        end
        STORE_WAIT: begin
          if (cnt == 4'd0) begin
            store_completed <= 1'b1;
            state           <= STORE_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STORE_DONE: begin
          if (!wren) begin
            store_completed <= 1'b0;
            state           <= RELEASE;
          end
        end
        RELEASE: begin
          // One guaranteed low cycle on both completions before re-accepting.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_cache_mem_responder
//
// Three responder instances (LATENCY 3, 1 and 15) share a clock and reset.
// A per-instance model array tracks memory contents; expected load data is
// pushed to a scoreboard queue when a load is driven and popped when the DUT
// raises load_completed.
// ----------------------------------------------------------------------------
module tb_cache_mem_responder;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [2:0][15:0]  address_in = '0;
  logic [2:0][31:0]  data_in = '0;
  logic [2:0]        wren = '0;
  logic [2:0]        mem_load_req = '0;
  logic [2:0][31:0]  data_out;
  logic [2:0]        load_completed;
  logic [2:0]        store_completed;
  logic [2:0]        load_toggle;
  logic [2:0]        busy;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] model [3][1024];
  logic [2:0]  tog_model = '0;
  logic [31:0] exp_q [$];

  int         ld_rises [3] = '{default: 0};
  int         st_rises [3] = '{default: 0};
  logic [2:0] lc_prev = '0;
  logic [2:0] sc_prev = '0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 1 : 15);
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cache_mem_responder #(
      .D_WIDTH   (32),
      .WIDTH_AD  (16),
      .DEPTH_LOG2(10),
      .LATENCY   ((g == 0) ? 3 : ((g == 1) ? 1 : 15))
    ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .address_in     (address_in[g]),
      .data_in        (data_in[g]),
      .wren           (wren[g]),
      .mem_load_req   (mem_load_req[g]),
      .data_out       (data_out[g]),
      .load_completed (load_completed[g]),
      .store_completed(store_completed[g]),
      .load_toggle    (load_toggle[g]),
      .busy           (busy[g])
    );
  end

  // Count rising edges of the completion flags to catch duplicate pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (load_completed[i] && !lc_prev[i]) ld_rises[i]++;
      if (store_completed[i] && !sc_prev[i]) st_rises[i]++;
    end
    lc_prev = load_completed;
    sc_prev = store_completed;
  end

  task automatic do_load(input int k, input logic [15:0] a, input bit chk_lat);
    int cyc;
    logic [31:0] exp;
    @(negedge clk);
    address_in[k]   = a;
    mem_load_req[k] = 1'b1;
    exp_q.push_back(model[k][a[11:2]]);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) address_in[k] = ~a;
    end while (load_completed[k] !== 1'b1 && cyc < 60);
    n_cmp++;
    if (load_completed[k] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL load_timeout inst=%0d addr=%h: load_completed=%b required 1", k, a, load_completed[k]);
    end
    if (chk_lat) begin
      n_cmp++;
      if (cyc !== lat_of(k) + 1) begin
        n_fail++;
        $display("[TB] FAIL load_latency inst=%0d: got %0d cycles required %0d", k, cyc - 1, lat_of(k));
      end
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (data_out[k] !== exp) begin
      n_fail++;
      $display("[TB] FAIL load_data inst=%0d addr=%h: data_out=%h required %h", k, a, data_out[k], exp);
    end
    tog_model[k] = ~tog_model[k];
    n_cmp++;
    if (load_toggle[k] !== tog_model[k]) begin
      n_fail++;
      $display("[TB] FAIL load_toggle inst=%0d: load_toggle=%b required %b", k, load_toggle[k], tog_model[k]);
    end
    mem_load_req[k] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({load_completed[k], busy[k]} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL load_release inst=%0d: {completed,busy}=%b required 01", k, {load_completed[k], busy[k]});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy[k], data_out[k]} !== {1'b0, exp}) begin
      n_fail++;
      $display("[TB] FAIL load_idle_hold inst=%0d: busy=%b data_out=%h required busy=0 data_out=%h", k, busy[k], data_out[k], exp);
    end
  endtask

  task automatic do_store(input int k, input logic [15:0] a, input logic [31:0] d, input bit drop_early);
    int cyc;
    @(negedge clk);
    address_in[k] = a;
    data_in[k]    = d;
    wren[k]       = 1'b1;
    model[k][a[11:2]] = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        address_in[k] = ~a;
        data_in[k]    = ~d;
        if (drop_early) wren[k] = 1'b0;
      end
    end while (store_completed[k] !== 1'b1 && cyc < 60);
    n_cmp++;
    if (store_completed[k] !== 1'b1 || cyc !== lat_of(k) + 1) begin
      n_fail++;
      $display("[TB] FAIL store_latency inst=%0d addr=%h: completed=%b after %0d cycles required 1 after %0d", k, a, store_completed[k], cyc - 1, lat_of(k));
    end
    wren[k] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({store_completed[k], busy[k]} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL store_release inst=%0d: {completed,busy}=%b required 01", k, {store_completed[k], busy[k]});
    end
    @(negedge clk);
    n_cmp++;
    if (busy[k] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL store_idle inst=%0d: busy=%b required 0", k, busy[k]);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({data_out[k], load_completed[k], store_completed[k], load_toggle[k], busy[k]} !== 36'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs inst=%0d: data_out=%h lc=%b sc=%b tog=%b busy=%b required all 0", k, data_out[k], load_completed[k], store_completed[k], load_toggle[k], busy[k]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({load_completed, store_completed, busy} !== 9'd0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: lc=%b sc=%b busy=%b required 0", load_completed, store_completed, busy);
    end
  endtask

  task automatic test_load();
    $display("[TB] load 0x0008 on LATENCY=3");
    do_load(0, 16'h0008, 1'b1);
  endtask

  task automatic test_store_load();
    $display("[TB] store 0xDEAD to 0x0004 then load it back");
    do_store(0, 16'h0004, 32'h0000DEAD, 1'b0);
    do_load(0, 16'h0004, 1'b1);
  endtask

  task automatic test_simultaneous();
    int cyc;
    int ld0;
    int st0;
    logic [15:0] a;
    logic [31:0] exp;
    $display("[TB] simultaneous store and load at 0x0010");
    a   = 16'h0010;
    ld0 = ld_rises[0];
    st0 = st_rises[0];
    @(negedge clk);
    address_in[0]   = a;
    data_in[0]      = 32'h0000BEEF;
    wren[0]         = 1'b1;
    mem_load_req[0] = 1'b1;
    model[0][a[11:2]] = 32'h0000BEEF;
    exp_q.push_back(model[0][a[11:2]]);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (store_completed[0] !== 1'b1 && cyc < 60);
    n_cmp++;
    if ({store_completed[0], load_completed[0]} !== 2'b10 || cyc !== 4) begin
      n_fail++;
      $display("[TB] FAIL simul_store_first: {sc,lc}=%b after %0d cycles required 10 after 3", {store_completed[0], load_completed[0]}, cyc - 1);
    end
    wren[0] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (load_completed[0] !== 1'b1 && cyc < 60);
    exp = exp_q.pop_front();
    n_cmp++;
    if (load_completed[0] !== 1'b1 || data_out[0] !== exp) begin
      n_fail++;
      $display("[TB] FAIL simul_load_data: lc=%b data_out=%h required lc=1 data_out=%h", load_completed[0], data_out[0], exp);
    end
    tog_model[0] = ~tog_model[0];
    mem_load_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ((ld_rises[0] - ld0) !== 1 || (st_rises[0] - st0) !== 1) begin
      n_fail++;
      $display("[TB] FAIL simul_pulse_count: loads=%0d stores=%0d required 1 and 1", ld_rises[0] - ld0, st_rises[0] - st0);
    end
    n_cmp++;
    if (load_toggle[0] !== tog_model[0]) begin
      n_fail++;
      $display("[TB] FAIL simul_toggle: load_toggle=%b required %b", load_toggle[0], tog_model[0]);
    end
  endtask

  task automatic test_drop_mid_wait();
    $display("[TB] store 0x1234 to 0x0020 with wren dropped during wait");
    do_store(0, 16'h0020, 32'h00001234, 1'b1);
    do_load(0, 16'h0020, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    $display("[TB] async reset while a load is in LOAD_WAIT");
    @(negedge clk);
    address_in[0]   = 16'h0008;
    mem_load_req[0] = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy[0], load_completed[0]} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL mid_load_inflight: {busy,lc}=%b required 10", {busy[0], load_completed[0]});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data_out[0], load_completed[0], store_completed[0], load_toggle[0], busy[0]} !== 36'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: data_out=%h lc=%b sc=%b tog=%b busy=%b required all 0", data_out[0], load_completed[0], store_completed[0], load_toggle[0], busy[0]);
    end
    mem_load_req[0] = 1'b0;
    tog_model = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_load(0, 16'h0004, 1'b1);
  endtask

  task automatic test_back_to_back();
    $display("[TB] four back-to-back loads on each LATENCY");
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        do_load(k, 16'(j * 4), 1'b1);
      end
    end
  endtask

  task automatic test_addr_alias();
    $display("[TB] byte-offset and high address bits ignored");
    do_load(1, 16'h1009, 1'b0);
    do_store(2, 16'hF03B, 32'hCAFE0001, 1'b0);
    do_load(2, 16'h003B, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1024; i++) begin
        model[k][i] = 32'(i);
      end
    end
    test_reset();
    test_load();
    test_store_load();
    test_simultaneous();
    test_drop_mid_wait();
    test_reset_mid_load();
    test_back_to_back();
    test_addr_alias();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
